// File: rtl/bti_pkg.sv
// BTI command encoding and the copy-engine FSM state type.
package bti_pkg;
    localparam logic BTI_CMD_RD = 1'b0;
    localparam logic BTI_CMD_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_DONE
    } copy_state_t;
endpackage

// File: rtl/bti_if.sv
// BTI request and response channels; both use vld/rdy handshakes.
interface bti_req_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            vld;
    logic            rdy;
    logic [AW-1:0]   addr;
    logic            cmd;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;

    modport mst (output vld, addr, cmd, data, strb, input rdy);
    modport slv (input vld, addr, cmd, data, strb, output rdy);
endinterface

interface bti_rsp_if_t #(
    parameter int DW = 32
);
    logic          vld;
    logic          rdy;
    logic [DW-1:0] data;

    modport mst (output vld, data, input rdy);
    modport slv (input vld, data, output rdy);
endinterface

// File: rtl/bti_copy_engine.sv
// Word-by-word BTI block copy, one transaction outstanding; 4 cycles/word with a 1-cycle slave.
// Stalls on req rdy or rsp vld simply hold the current state; request fields never change mid-stall.
module bti_copy_engine
    import bti_pkg::*;
#(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BTI_AW-1:0] src_addr,
    input  logic [BTI_AW-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    bti_req_if_t.mst          bti_req_mst,
    bti_rsp_if_t.slv          bti_rsp_slv
);
    localparam int                WORD_BYTES = BTI_DW / 8;
    localparam logic [BTI_AW-1:0] ADDR_MASK  = ~BTI_AW'(WORD_BYTES - 1);
    localparam logic [BTI_AW-1:0] ADDR_STEP  = BTI_AW'(WORD_BYTES);

    copy_state_t       state;
    copy_state_t       state_nxt;
    logic [BTI_AW-1:0] src_ptr;
    logic [BTI_AW-1:0] dst_ptr;
    logic [LEN_W-1:0]  remain;
    logic [BTI_DW-1:0] data_q;
    logic              req_hs;
    logic              rsp_hs;

    assign req_hs = bti_req_mst.vld && bti_req_mst.rdy;
    assign rsp_hs = bti_rsp_slv.vld && bti_rsp_slv.rdy;

    always_comb begin
        state_nxt        = state;
        busy             = (state != ST_IDLE);
        done             = (state == ST_DONE);
        bti_req_mst.vld  = 1'b0;
        bti_req_mst.cmd  = BTI_CMD_RD;
        bti_req_mst.addr = src_ptr;
        bti_req_mst.data = data_q;
        bti_req_mst.strb = '0;
        bti_rsp_slv.rdy  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = (len == '0) ? ST_DONE : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                bti_req_mst.vld = 1'b1;
                if (req_hs) state_nxt = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                bti_rsp_slv.rdy = 1'b1;
                if (rsp_hs) state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                bti_req_mst.vld  = 1'b1;
                bti_req_mst.cmd  = BTI_CMD_WR;
                bti_req_mst.addr = dst_ptr;
                bti_req_mst.strb = '1;
                if (req_hs) state_nxt = ST_WR_RSP;
            end
            ST_WR_RSP: begin
                bti_rsp_slv.rdy = 1'b1;
                if (rsp_hs) state_nxt = (remain == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            remain  <= '0;
            data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                src_ptr <= src_addr & ADDR_MASK;
                dst_ptr <= dst_addr & ADDR_MASK;
                remain  <= len;
            end
            if (state == ST_RD_RSP && rsp_hs) data_q <= bti_rsp_slv.data;
            // Pointers advance only once the write is acknowledged, so wrap is plain modular add.
            if (state == ST_WR_RSP && rsp_hs) begin
                src_ptr <= src_ptr + ADDR_STEP;
                dst_ptr <= dst_ptr + ADDR_STEP;
                remain  <= remain - LEN_W'(1);
            end
        end
    end

    rsp_only_when_expected: assert property (@(posedge clk) disable iff (!rst_n)
        bti_rsp_slv.vld |-> (state == ST_RD_RSP || state == ST_WR_RSP));
endmodule

// File: tb/tb_bti_copy_engine.sv
// Directed and randomized copies against a memory-level reference model of the block copy.
module tb_bti_copy_engine;
    import bti_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } hs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;

    bti_req_if_t #(.AW(AW), .DW(DW)) req_if ();
    bti_rsp_if_t #(.DW(DW))          rsp_if ();

    bti_copy_engine #(.BTI_AW(AW), .BTI_DW(DW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .bti_req_mst (req_if.mst),
        .bti_rsp_slv (rsp_if.slv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave memory and its reference twin.
    logic [31:0] mem     [bit [31:0]];
    logic [31:0] exp_mem [bit [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Monitor / slave state and logs.
    int   req_stall = 0;
    int   rsp_delay = 0;
    int   t0 = 0;
    hs_t  hs_q[$];
    hs_t  exp_hs[$];
    int   done_q[$];
    int   busy_cnt = 0;
    int   vld_cnt = 0;
    int   wr_cnt = 0;

    initial begin
        int          stall_cnt;
        int          dly_cnt;
        bit          pend;
        bit          holding;
        bit          prev_req_vld;
        bit          prev_rsp_rdy;
        logic [31:0] pend_data;
        hs_t         hold;
        stall_cnt = 0; dly_cnt = 0; pend = 0; holding = 0;
        prev_req_vld = 0; prev_rsp_rdy = 0; pend_data = '0;
        hold = '{1'b0, 32'h0, 32'h0, 4'h0};
        req_if.rdy = 1'b0;
        rsp_if.vld = 1'b0;
        rsp_if.data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; holding = 0; prev_req_vld = 0; prev_rsp_rdy = 0;
                req_if.rdy = 1'b0;
                rsp_if.vld = 1'b0;
                continue;
            end
            // Transfers that happened at the posedge just passed.
            if (rsp_if.vld && prev_rsp_rdy) begin
                rsp_if.vld = 1'b0;
                pend = 0;
            end
            if (prev_req_vld && req_if.rdy) begin
                hs_q.push_back(hold);
                if (hold.cmd == BTI_CMD_WR) begin
                    mem[hold.addr] = hold.data;
                    wr_cnt++;
                    pend_data = 32'hDEAD_BEEF;
                end else begin
                    pend_data = mem.exists(hold.addr) ? mem[hold.addr] : dflt(hold.addr);
                end
                pend = 1; dly_cnt = rsp_delay; holding = 0;
            end
            // Current request channel.
            if (req_if.vld) begin
                vld_cnt++;
                if (!holding) begin
                    holding = 1; stall_cnt = 0;
                    hold = '{req_if.cmd, req_if.addr, req_if.data, req_if.strb};
                end else begin
                    chk("stall_cmd",  req_if.cmd,  hold.cmd);
                    chk("stall_addr", req_if.addr, hold.addr);
                    chk("stall_data", req_if.data, hold.data);
                end
                if (stall_cnt < req_stall) begin
                    stall_cnt++;
                    req_if.rdy = 1'b0;
                end else begin
                    req_if.rdy = 1'b1;
                end
            end else begin
                req_if.rdy = 1'b0;
            end
            if (pend && !rsp_if.vld) begin
                if (dly_cnt == 0) begin
                    rsp_if.vld = 1'b1;
                    rsp_if.data = pend_data;
                end else begin
                    dly_cnt--;
                end
            end
            prev_req_vld = req_if.vld;
            prev_rsp_rdy = rsp_if.rdy;
            if (busy) busy_cnt++;
            if (done) done_q.push_back(cyc - t0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Reference: ascending word copy over a flat memory, addresses word-aligned, 32-bit wrap.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sp, dp, w;
        sp = s & ~32'h3;
        dp = d & ~32'h3;
        for (int i = 0; i < n; i++) begin
            w = exp_mem.exists(sp) ? exp_mem[sp] : dflt(sp);
            exp_hs.push_back('{BTI_CMD_RD, sp, 32'h0, 4'h0});
            exp_hs.push_back('{BTI_CMD_WR, dp, w, 4'hF});
            exp_mem[dp] = w;
            sp = sp + 32'd4;
            dp = dp + 32'd4;
        end
    endtask

    task automatic preload(input logic [31:0] a, input int n);
        logic [31:0] p, w;
        p = a & ~32'h3;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            mem[p] = w;
            exp_mem[p] = w;
            p = p + 32'd4;
        end
    endtask

    task automatic clear_logs();
        hs_q.delete(); exp_hs.delete(); done_q.delete();
        busy_cnt = 0; vld_cnt = 0; wr_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk); #1;
        src_addr = s; dst_addr = d; len = LW'(n); start = 1'b1;
        t0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_q.size() > 0) break;
            @(negedge clk); #1;
        end
        chk({tag, "_done_seen"}, done_q.size() > 0, 1);
        repeat (4) @(negedge clk);
        #1;
        chk({tag, "_done_count"}, done_q.size(), 1);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    task automatic check_traffic(input string tag);
        chk({tag, "_nhs"}, hs_q.size(), exp_hs.size());
        for (int i = 0; i < exp_hs.size() && i < hs_q.size(); i++) begin
            chk($sformatf("%s_cmd%0d", tag, i), hs_q[i].cmd, exp_hs[i].cmd);
            chk($sformatf("%s_addr%0d", tag, i), hs_q[i].addr, exp_hs[i].addr);
            if (exp_hs[i].cmd == BTI_CMD_WR) begin
                chk($sformatf("%s_wdata%0d", tag, i), hs_q[i].data, exp_hs[i].data);
                chk($sformatf("%s_strb%0d", tag, i), hs_q[i].strb, exp_hs[i].strb);
            end
        end
    endtask

    task automatic check_mem(input string tag);
        chk({tag, "_mem_num"}, mem.num(), exp_mem.num());
        foreach (exp_mem[a])
            chk($sformatf("%s_mem_%08h", tag, a), mem.exists(a) ? mem[a] : 32'hx, exp_mem[a]);
    endtask

    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int stall, input int dly, input bit timed);
        req_stall = stall; rsp_delay = dly;
        clear_logs();
        model_copy(s, d, n);
        do_start(s, d, n);
        wait_done(tag, 60 * (n + 1));
        if (timed) begin
            chk({tag, "_done_cycle"}, (done_q.size() > 0) ? done_q[0] : -1, 4 * n + 1);
            chk({tag, "_busy_cycles"}, busy_cnt, 4 * n + 1);
        end
        check_traffic(tag);
        check_mem(tag);
    endtask

    initial begin
        logic [31:0] s, d;
        int          n;
        bit          found;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req_vld", req_if.vld, 0);
        chk("rst_rsp_rdy", rsp_if.rdy, 0);
        chk("rst_req_addr", req_if.addr, 0);
        chk("rst_req_data", req_if.data, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Basic copy of 4 known words
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 4 * i] = 32'h1111_1111 * (i + 1);
            exp_mem[32'h100 + 4 * i] = 32'h1111_1111 * (i + 1);
        end
        run_copy("basic", 32'h100, 32'h200, 4, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("basic_word%0d", i), mem[32'h200 + 4 * i], 32'h1111_1111 * (i + 1));

        // Zero length
        run_copy("zero", 32'h400, 32'h500, 0, 0, 0, 1);
        chk("zero_no_vld", vld_cnt, 0);

        // Backpressure on both channels
        preload(32'h600, 2);
        run_copy("bp", 32'h600, 32'h700, 2, 3, 2, 0);

        // Start while busy is ignored
        preload(32'h800, 3);
        req_stall = 0; rsp_delay = 0;
        clear_logs();
        model_copy(32'h800, 32'h900, 3);
        do_start(32'h800, 32'h900, 3);
        for (int k = 0; k < 50 && (cyc - t0) < 5; k++) begin
            @(negedge clk); #1;
        end
        src_addr = 32'hA00; dst_addr = 32'hB00; len = 16'd2; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done("sbusy", 200);
        check_traffic("sbusy");
        check_mem("sbusy");
        chk("sbusy_no_b00", mem.exists(32'hB00), 0);

        // Reset during WR_REQ of word 2 of 4
        preload(32'hC00, 4);
        clear_logs();
        do_start(32'hC00, 32'hD00, 4);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (req_if.vld && req_if.cmd == BTI_CMD_WR && wr_cnt == 2) begin
                found = 1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("rmid_reached_wr2", found, 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        chk("rmid_vld", req_if.vld, 0);
        model_copy(32'hC00, 32'hD00, 2);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        check_mem("rmid");
        chk("rmid_word2_unwritten", mem.exists(32'hD08), 0);
        preload(32'hE00, 3);
        run_copy("rmid_after", 32'hE00, 32'hF00, 3, 0, 0, 1);

        // Wrap and alignment
        run_copy("wrap", 32'hFFFF_FFFB, 32'h1000, 3, 0, 0, 1);
        if (hs_q.size() == 6) begin
            chk("wrap_rd0", hs_q[0].addr, 32'hFFFF_FFF8);
            chk("wrap_rd1", hs_q[2].addr, 32'hFFFF_FFFC);
            chk("wrap_rd2", hs_q[4].addr, 32'h0000_0000);
        end

        // Randomized copies, some overlapping
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 6);
            s = $urandom;
            if (t % 2 == 0) d = s + 32'(4 * $urandom_range(1, 3));
            else            d = $urandom;
            preload(s, n);
            run_copy($sformatf("rnd%0d", t), s, d, n,
                     $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
        run_copy("rnd_timed", $urandom, $urandom, 5, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
